// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB initiator controller and its address decoder.
package apb_master_pkg;

    localparam int unsigned NUM_SLV   = 5;
    localparam int unsigned SLV_IDX_W = 3;
    localparam int unsigned RESP_W    = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RESP   = 3'd3,
        ST_DECERR = 3'd4
    } state_e;

    // Timeout counter width: enough to hold the limit, clamped to 8..16 bits.
    function automatic int unsigned tmo_cnt_width(input int unsigned cyc);
        int unsigned w;
        w = $clog2(cyc + 1);
        if (w < 8)  w = 8;
        if (w > 16) w = 16;
        return w;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Slave-index decoder: index 0..4 selects one slave (index 0 -> MSB of the one-hot), 5..7 miss.
module apb_addr_decode
    import apb_master_pkg::*;
(
    input  logic [SLV_IDX_W-1:0] idx,
    output logic                 hit_c,
    output logic [NUM_SLV-1:0]   psel_onehot_c
);

    always_comb begin
        psel_onehot_c = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (idx == SLV_IDX_W'(i)) begin
                psel_onehot_c[NUM_SLV-1-i] = 1'b1;
            end
        end
        hit_c = |psel_onehot_c;
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB initiator: one CPU request at a time, SETUP/ACCESS sequencing, single-cycle response.
// Optional ACCESS-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_ctrl
    import apb_master_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SLV_LSB     = 12,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic               req_write,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               rsp_valid,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic [RESP_W-1:0]  rsp_resp,
    output logic [NUM_SLV-1:0] psel,
    output logic               penable,
    output logic [ADDR_W-1:0]  paddr,
    output logic               pwrite,
    output logic [DATA_W-1:0]  pwdata,
    input  logic               ready_final,
    input  logic [DATA_W-1:0]  rdata_final,
    input  logic [RESP_W-1:0]  resp_final
);

    state_e state;
    state_e state_next;

    logic               dec_hit;
    logic [NUM_SLV-1:0] dec_psel;
    logic               timeout_hit;

    logic               req_ready_n;
    logic               rsp_valid_n;
    logic [DATA_W-1:0]  rsp_rdata_n;
    logic [RESP_W-1:0]  rsp_resp_n;
    logic [NUM_SLV-1:0] psel_n;
    logic               penable_n;
    logic [ADDR_W-1:0]  paddr_n;
    logic               pwrite_n;
    logic [DATA_W-1:0]  pwdata_n;

    apb_addr_decode u_decode (
        .idx           (req_addr[SLV_LSB +: SLV_IDX_W]),
        .hit_c         (dec_hit),
        .psel_onehot_c (dec_psel)
    );

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned TMO_W = tmo_cnt_width(TIMEOUT_CYC);

    logic [TMO_W-1:0] tmo_cnt;

    // Counts not-ready ACCESS cycles; cleared in SETUP so each transfer starts fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == ST_SETUP) begin
            tmo_cnt <= '0;
        end else if (state == ST_ACCESS && !ready_final) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Fires on the TIMEOUT_CYC-th not-ready cycle; a same-cycle ready takes priority.
    assign timeout_hit = (state == ST_ACCESS) && !ready_final
                         && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = dec_hit ? ST_SETUP : ST_DECERR;
                end
            end
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: begin
                if (ready_final || timeout_hit) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP:   state_next = ST_IDLE;
            ST_DECERR: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output next-values; registered below so every port is flop-driven
    always_comb begin
        req_ready_n = (state_next == ST_IDLE);
        rsp_valid_n = 1'b0;
        rsp_rdata_n = rsp_rdata;
        rsp_resp_n  = rsp_resp;
        psel_n      = psel;
        penable_n   = penable;
        paddr_n     = paddr;
        pwrite_n    = pwrite;
        pwdata_n    = pwdata;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    paddr_n  = req_addr;
                    pwrite_n = req_write;
                    pwdata_n = req_wdata;
                    psel_n   = dec_psel;
                    if (!dec_hit) begin
                        rsp_valid_n = 1'b1;
                        rsp_resp_n  = RESP_DECERR;
                        rsp_rdata_n = '0;
                    end
                end
            end
            ST_SETUP: begin
                penable_n = 1'b1;
            end
            ST_ACCESS: begin
                if (ready_final) begin
                    psel_n      = '0;
                    penable_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_resp_n  = resp_final;
                    rsp_rdata_n = pwrite ? '0 : rdata_final;
                end else if (timeout_hit) begin
                    psel_n      = '0;
                    penable_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_resp_n  = RESP_SLVERR;
                    rsp_rdata_n = '0;
                end
            end
            default: begin
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
            psel      <= '0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
        end else begin
            req_ready <= req_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_resp  <= rsp_resp_n;
            psel      <= psel_n;
            penable   <= penable_n;
            paddr     <= paddr_n;
            pwrite    <= pwrite_n;
            pwdata    <= pwdata_n;
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed self-checking bench for apb_master_ctrl; timeout scenario runs when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master_ctrl;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [4:0]  psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        ready_final;
    logic [31:0] rdata_final;
    logic [1:0]  resp_final;

    int checks   = 0;
    int failures = 0;

    apb_master_ctrl #(
        .ADDR_W(32), .DATA_W(32), .SLV_LSB(12), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .ready_final(ready_final), .rdata_final(rdata_final), .resp_final(resp_final)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
        ready_final = 1'b0; rdata_final = '0; resp_final = 2'b00;
        tick; tick;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (psel !== 5'b00000 || penable !== 1'b0) begin failures++; $display("FAIL reset_psel got=%b/%b exp=00000/0", psel, penable); end
        checks++; if (paddr !== 32'h0 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_data got=%h/%b/%h exp=0/00/0", paddr, rsp_resp, rsp_rdata); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_read;
        req_valid = 1'b1; req_addr = 32'h0000_2004; req_write = 1'b0;
        ready_final = 1'b1; rdata_final = 32'hCAFE_F00D; resp_final = 2'b00;
        tick;
        req_valid = 1'b0;
        checks++; if (psel !== 5'b00100 || penable !== 1'b0) begin failures++; $display("FAIL read_setup got=%b/%b exp=00100/0", psel, penable); end
        checks++; if (paddr !== 32'h0000_2004 || pwrite !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL read_setup_addr got=%h/%b/%b exp=00002004/0/0", paddr, pwrite, req_ready); end
        tick;
        checks++; if (psel !== 5'b00100 || penable !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL read_access got=%b/%b/%b exp=00100/1/0", psel, penable, rsp_valid); end
        tick;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D || rsp_resp !== 2'b00) begin failures++; $display("FAIL read_rsp got=%b/%h/%b exp=1/cafef00d/00", rsp_valid, rsp_rdata, rsp_resp); end
        checks++; if (psel !== 5'b00000 || penable !== 1'b0) begin failures++; $display("FAIL read_rsp_bus got=%b/%b exp=00000/0", psel, penable); end
        tick;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL read_idle got=%b/%b/%h exp=0/1/cafef00d", rsp_valid, req_ready, rsp_rdata); end
    endtask

    task automatic test_decerr;
        req_valid = 1'b1; req_addr = 32'h0000_6000; req_write = 1'b0;
        tick;
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b11 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL decerr_rsp got=%b/%b/%h exp=1/11/0", rsp_valid, rsp_resp, rsp_rdata); end
        checks++; if (psel !== 5'b00000 || penable !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL decerr_bus got=%b/%b/%b exp=00000/0/0", psel, penable, req_ready); end
        tick;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_resp !== 2'b11 || psel !== 5'b00000) begin failures++; $display("FAIL decerr_idle got=%b/%b/%b/%b exp=0/1/11/00000", rsp_valid, req_ready, rsp_resp, psel); end
    endtask

    task automatic test_write_wait;
        int pulses;
        pulses = 0;
        req_valid = 1'b1; req_addr = 32'h0000_0010; req_write = 1'b1; req_wdata = 32'h1234_5678;
        ready_final = 1'b0; rdata_final = 32'hDEAD_BEEF; resp_final = 2'b00;
        tick;
        req_valid = 1'b0; req_wdata = 32'h0; req_addr = 32'hFFFF_FFFF;
        checks++; if (psel !== 5'b10000 || pwrite !== 1'b1 || pwdata !== 32'h1234_5678) begin failures++; $display("FAIL write_setup got=%b/%b/%h exp=10000/1/12345678", psel, pwrite, pwdata); end
        tick;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (penable !== 1'b1 || psel !== 5'b10000 || pwdata !== 32'h1234_5678 || paddr !== 32'h0000_0010 || rsp_valid !== 1'b0) begin
                failures++; $display("FAIL write_access_%0d got=%b/%b/%h/%h/%b exp=1/10000/12345678/00000010/0", i, penable, psel, pwdata, paddr, rsp_valid);
            end
            if (i == 4) ready_final = 1'b1;
            tick;
        end
        ready_final = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_resp !== 2'b00 || penable !== 1'b0) begin failures++; $display("FAIL write_rsp got=%b/%h/%b/%b exp=1/0/00/0", rsp_valid, rsp_rdata, rsp_resp, penable); end
        for (int i = 0; i < 3; i++) begin
            tick;
            if (rsp_valid === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL write_single_pulse extra_pulses=%0d exp=0", pulses); end
    endtask

    task automatic test_slverr;
        req_valid = 1'b1; req_addr = 32'h0000_4008; req_write = 1'b0;
        ready_final = 1'b1; rdata_final = 32'h0BAD_0BAD; resp_final = 2'b10;
        tick;
        req_valid = 1'b0;
        checks++; if (psel !== 5'b00001) begin failures++; $display("FAIL slverr_psel got=%b exp=00001", psel); end
        tick; tick;
        checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b10 || rsp_rdata !== 32'h0BAD_0BAD) begin failures++; $display("FAIL slverr_rsp got=%b/%b/%h exp=1/10/0bad0bad", rsp_valid, rsp_resp, rsp_rdata); end
        resp_final = 2'b00;
        tick;
    endtask

    task automatic test_back_to_back;
        req_valid = 1'b1; req_addr = 32'h0000_1000; req_write = 1'b1; req_wdata = 32'hA5A5_0001;
        ready_final = 1'b1; rdata_final = 32'h5555_AAAA;
        tick;
        req_addr = 32'h0000_3000; req_write = 1'b0; req_wdata = 32'h0;
        checks++; if (psel !== 5'b01000 || paddr !== 32'h0000_1000) begin failures++; $display("FAIL b2b_first_setup got=%b/%h exp=01000/00001000", psel, paddr); end
        tick;
        checks++; if (paddr !== 32'h0000_1000 || pwrite !== 1'b1 || pwdata !== 32'hA5A5_0001 || req_ready !== 1'b0) begin failures++; $display("FAIL b2b_hold got=%h/%b/%h/%b exp=00001000/1/a5a50001/0", paddr, pwrite, pwdata, req_ready); end
        tick;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL b2b_first_rsp got=%b/%h exp=1/0", rsp_valid, rsp_rdata); end
        tick;
        checks++; if (req_ready !== 1'b1 || psel !== 5'b00000) begin failures++; $display("FAIL b2b_idle got=%b/%b exp=1/00000", req_ready, psel); end
        tick;
        req_valid = 1'b0;
        checks++; if (psel !== 5'b00010 || paddr !== 32'h0000_3000 || pwrite !== 1'b0) begin failures++; $display("FAIL b2b_second_setup got=%b/%h/%b exp=00010/00003000/0", psel, paddr, pwrite); end
        tick; tick;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h5555_AAAA) begin failures++; $display("FAIL b2b_second_rsp got=%b/%h exp=1/5555aaaa", rsp_valid, rsp_rdata); end
        tick;
    endtask

    task automatic test_reset_mid;
        int pulses;
        pulses = 0;
        req_valid = 1'b1; req_addr = 32'h0000_2000; req_write = 1'b0; ready_final = 1'b0;
        tick;
        req_valid = 1'b0;
        tick;
        checks++; if (penable !== 1'b1 || psel !== 5'b00100) begin failures++; $display("FAIL rstmid_access got=%b/%b exp=1/00100", penable, psel); end
        reset = 1'b1;
        #1;
        checks++; if (psel !== 5'b00000 || penable !== 1'b0 || req_ready !== 1'b1 || paddr !== 32'h0) begin failures++; $display("FAIL rstmid_async got=%b/%b/%b/%h exp=00000/0/1/0", psel, penable, req_ready, paddr); end
        tick;
        reset = 1'b0; ready_final = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (rsp_valid === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0 || req_ready !== 1'b1 || penable !== 1'b0) begin failures++; $display("FAIL rstmid_after got=%0d/%b/%b exp=0/1/0", pulses, req_ready, penable); end
    endtask

`ifdef APB_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        req_valid = 1'b1; req_addr = 32'h0000_0020; req_write = 1'b0;
        ready_final = 1'b0; rdata_final = 32'h7777_7777; resp_final = 2'b00;
        tick;
        req_valid = 1'b0;
        tick;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (penable !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL tmo_wait_%0d got=%b/%b exp=1/0", i, penable, rsp_valid); end
            tick;
        end
        checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b10 || rsp_rdata !== 32'h0 || penable !== 1'b0 || psel !== 5'b00000) begin failures++; $display("FAIL tmo_rsp got=%b/%b/%h/%b/%b exp=1/10/0/0/00000", rsp_valid, rsp_resp, rsp_rdata, penable, psel); end
        tick;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0; rdata_final = 32'h1111_2222;
        tick;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (penable !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL tmo_race_wait_%0d got=%b/%b exp=1/0", i, penable, rsp_valid); end
            if (i == 8) ready_final = 1'b1;
            tick;
        end
        ready_final = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h1111_2222) begin failures++; $display("FAIL tmo_race_rsp got=%b/%b/%h exp=1/00/11112222", rsp_valid, rsp_resp, rsp_rdata); end
        tick;
    endtask
`else
    task automatic test_no_timeout;
        int pulses;
        pulses = 0;
        req_valid = 1'b1; req_addr = 32'h0000_0020; req_write = 1'b0;
        ready_final = 1'b0; rdata_final = 32'h7777_7777; resp_final = 2'b00;
        tick;
        req_valid = 1'b0;
        tick;
        for (int i = 0; i < 300; i++) begin
            tick;
            if (rsp_valid === 1'b1 || penable !== 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL notmo_wait bad_cycles=%0d exp=0", pulses); end
        ready_final = 1'b1;
        tick;
        ready_final = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h7777_7777) begin failures++; $display("FAIL notmo_rsp got=%b/%b/%h exp=1/00/77777777", rsp_valid, rsp_resp, rsp_rdata); end
        tick;
    endtask
`endif

    initial begin
        test_reset;
        test_read;
        test_decerr;
        test_write_wait;
        test_slverr;
        test_back_to_back;
        test_reset_mid;
`ifdef APB_MASTER_TIMEOUT_EN
        test_timeout;
`else
        test_no_timeout;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
